// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_scoreboard
// Purpose  : Busy-bit scoreboard for the 32-entry register file. Tracks
//            registers with a write in flight, stalls issue on RAW and
//            (optionally) WAW hazards, and flags protocol errors on
//            completions that do not match an outstanding write.
// Revision : 1.0 - initial release
// ============================================================================
module rf_scoreboard #(
  parameter int STALL_ON_WAW = 1,
  parameter int CNT_W        = 6
) (
  input  logic             clk,
  input  logic             rst,
  // issue side
  input  logic             iss_valid,
  input  logic [4:0]       iss_rs1,
  input  logic             iss_use_rs1,
  input  logic [4:0]       iss_rs2,
  input  logic             iss_use_rs2,
  input  logic [4:0]       iss_rd,
  input  logic             iss_rd_we,
  output logic             iss_ready,
  // writeback port 0 (ALU/ext/PC+4) and port 1 (load data)
  input  logic             wb0_valid,
  input  logic [4:0]       wb0_rd,
  input  logic             wb1_valid,
  input  logic [4:0]       wb1_rd,
  // control / status
  input  logic             flush,
  output logic [31:0]      busy,
  output logic [CNT_W-1:0] outstanding,
  output logic             err
);

  localparam logic [31:0] c_ONE   = 32'd1;
  localparam logic [31:0] c_NO_X0 = 32'hFFFF_FFFE;

  logic [31:0]      r_busy;
  logic [CNT_W-1:0] r_outstanding;
  logic             r_err;

  logic             w_raw1;
  logic             w_raw2;
  logic             w_waw;
  logic             w_accept;
  logic [31:0]      w_set;
  logic [31:0]      w_clr0;
  logic [31:0]      w_clr1;
  logic [31:0]      w_clr_eff;
  logic [31:0]      w_busy_next;
  logic             w_inc;
  logic             w_dec0;
  logic             w_dec1;
  logic             w_err_set;
  logic [CNT_W-1:0] w_out_next;

  // Hazard detection looks only at the registered busy vector, so a completion
  // in the current cycle never unblocks issue until the following cycle.
  always_comb begin
    w_raw1    = iss_use_rs1 && (iss_rs1 != 5'd0) && r_busy[iss_rs1];
    w_raw2    = iss_use_rs2 && (iss_rs2 != 5'd0) && r_busy[iss_rs2];
    w_waw     = (STALL_ON_WAW != 0) && iss_rd_we && (iss_rd != 5'd0) && r_busy[iss_rd];
    iss_ready = !flush && !w_raw1 && !w_raw2 && !w_waw;
    w_accept  = iss_valid && iss_ready;
  end

  // One-hot set/clear requests; x0 and anything arriving with flush are dropped.
  always_comb begin
    w_set  = '0;
    w_clr0 = '0;
    w_clr1 = '0;
    if (w_accept && iss_rd_we && (iss_rd != 5'd0))
      w_set = c_ONE << iss_rd;
    if (!flush && wb0_valid && (wb0_rd != 5'd0))
      w_clr0 = c_ONE << wb0_rd;
    if (!flush && wb1_valid && (wb1_rd != 5'd0))
      w_clr1 = c_ONE << wb1_rd;
  end

  // Next busy vector, counter deltas and error detection. A set on the same
  // register as a clear wins, so that clear is not counted as effective.
  always_comb begin
    w_clr_eff   = (w_clr0 | w_clr1) & r_busy & ~w_set;
    w_busy_next = ((r_busy & ~w_clr_eff) | w_set) & c_NO_X0;
    w_inc       = |(w_set & ~r_busy);
    w_dec0      = |(w_clr0 & w_clr_eff);
    // Port 1 only counts when it names a different register than port 0,
    // so a double completion of one register decrements once.
    w_dec1      = |(w_clr1 & ~w_clr0 & w_clr_eff);
    w_err_set   = (|(w_clr0 & ~r_busy)) || (|(w_clr1 & ~r_busy)) || (|(w_clr0 & w_clr1));
    w_out_next  = r_outstanding + CNT_W'(w_inc) - CNT_W'(w_dec0) - CNT_W'(w_dec1);
  end

  // Busy vector and outstanding counter; flush empties both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy        <= '0;
      r_outstanding <= '0;
    end else if (flush) begin
      r_busy        <= '0;
      r_outstanding <= '0;
    end else begin
      r_busy        <= w_busy_next;
      r_outstanding <= w_out_next;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err <= 1'b0;
    else if (w_err_set)
      r_err <= 1'b1;
  end

  assign busy        = r_busy;
  assign outstanding = r_outstanding;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_scoreboard
// Purpose  : Directed self-checking bench for rf_scoreboard. Two instances
//            share stimulus: u_dut stalls on WAW, u_dut_nw does not.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_scoreboard;

  localparam int c_CNT_W = 6;

  logic             clk;
  logic             rst;
  logic             iss_valid;
  logic [4:0]       iss_rs1;
  logic             iss_use_rs1;
  logic [4:0]       iss_rs2;
  logic             iss_use_rs2;
  logic [4:0]       iss_rd;
  logic             iss_rd_we;
  logic             wb0_valid;
  logic [4:0]       wb0_rd;
  logic             wb1_valid;
  logic [4:0]       wb1_rd;
  logic             flush;

  logic             ready_a, ready_b;
  logic [31:0]      busy_a, busy_b;
  logic [c_CNT_W-1:0] out_a, out_b;
  logic             err_a, err_b;

  int errors = 0;
  int checks = 0;

  rf_scoreboard #(.STALL_ON_WAW(1), .CNT_W(c_CNT_W)) u_dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_use_rs1(iss_use_rs1),
    .iss_rs2(iss_rs2), .iss_use_rs2(iss_use_rs2), .iss_rd(iss_rd),
    .iss_rd_we(iss_rd_we), .iss_ready(ready_a),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb1_valid(wb1_valid), .wb1_rd(wb1_rd),
    .flush(flush), .busy(busy_a), .outstanding(out_a), .err(err_a)
  );

  rf_scoreboard #(.STALL_ON_WAW(0), .CNT_W(c_CNT_W)) u_dut_nw (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_use_rs1(iss_use_rs1),
    .iss_rs2(iss_rs2), .iss_use_rs2(iss_use_rs2), .iss_rd(iss_rd),
    .iss_rd_we(iss_rd_we), .iss_ready(ready_b),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb1_valid(wb1_valid), .wb1_rd(wb1_rd),
    .flush(flush), .busy(busy_b), .outstanding(out_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid   = 1'b0;
    iss_rs1     = 5'd0;
    iss_use_rs1 = 1'b0;
    iss_rs2     = 5'd0;
    iss_use_rs2 = 1'b0;
    iss_rd      = 5'd0;
    iss_rd_we   = 1'b0;
    wb0_valid   = 1'b0;
    wb0_rd      = 5'd0;
    wb1_valid   = 1'b0;
    wb1_rd      = 5'd0;
    flush       = 1'b0;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    idle();
    iss_valid = 1'b1;
    iss_rd    = rd;
    iss_rd_we = 1'b1;
    step();
    idle();
  endtask

  // Reset pulse placed between clock edges so only the async path can act.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_busy", busy_a, 32'h0);
    chk("rst_out", 32'(out_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    #1 chk("rst_ready", 32'(ready_a), 32'd1);

    // RAW: issue rd=5, dependent read stalls until the cycle after writeback
    issue_wr(5'd5);
    chk("raw_busy5", busy_a, 32'h0000_0020);
    chk("raw_out1", 32'(out_a), 32'd1);
    iss_valid = 1'b1; iss_use_rs1 = 1'b1; iss_rs1 = 5'd5;
    #1 chk("raw_stall", 32'(ready_a), 32'd0);
    wb0_valid = 1'b1; wb0_rd = 5'd5;
    #1 chk("raw_stall_wb_cycle", 32'(ready_a), 32'd0);
    step();
    wb0_valid = 1'b0;
    #1 chk("raw_release", 32'(ready_a), 32'd1);
    chk("raw_busy_clr", busy_a, 32'h0);
    chk("raw_out0", 32'(out_a), 32'd0);
    step();
    idle();

    // Writes and completions to x0 are ignored
    issue_wr(5'd0);
    wb1_valid = 1'b1; wb1_rd = 5'd0;
    step();
    idle();
    chk("x0_busy", busy_a, 32'h0);
    chk("x0_out", 32'(out_a), 32'd0);
    chk("x0_err", 32'(err_a), 32'd0);
    issue_wr(5'd4);
    iss_valid = 1'b1; iss_use_rs1 = 1'b1; iss_rs1 = 5'd0; iss_use_rs2 = 1'b1; iss_rs2 = 5'd0;
    #1 chk("x0_no_stall", 32'(ready_a), 32'd1);
    idle();
    wb0_valid = 1'b1; wb0_rd = 5'd4;
    step();
    idle();
    chk("x0_cleanup", busy_a, 32'h0);

    // WAW: stalling instance blocks, non-stalling one lets set win over clear
    issue_wr(5'd7);
    chk("waw_busy7", busy_a, 32'h0000_0080);
    iss_valid = 1'b1; iss_rd = 5'd7; iss_rd_we = 1'b1;
    wb0_valid = 1'b1; wb0_rd = 5'd7;
    #1 chk("waw_stall", 32'(ready_a), 32'd0);
    chk("waw_nostall", 32'(ready_b), 32'd1);
    step();
    idle();
    chk("waw_a_busy", busy_a, 32'h0);
    chk("waw_a_out", 32'(out_a), 32'd0);
    chk("waw_b_busy", busy_b, 32'h0000_0080);
    chk("waw_b_out", 32'(out_b), 32'd1);
    chk("waw_b_err", 32'(err_b), 32'd0);
    flush = 1'b1;
    step();
    idle();
    chk("waw_b_flushed", busy_b, 32'h0);

    // Dual completion of distinct registers
    issue_wr(5'd3);
    issue_wr(5'd9);
    chk("dual_busy", busy_a, 32'h0000_0208);
    chk("dual_out2", 32'(out_a), 32'd2);
    wb0_valid = 1'b1; wb0_rd = 5'd3; wb1_valid = 1'b1; wb1_rd = 5'd9;
    step();
    idle();
    chk("dual_clr", busy_a, 32'h0);
    chk("dual_out0", 32'(out_a), 32'd0);
    chk("dual_err0", 32'(err_a), 32'd0);

    // Both ports complete the same register: cleared once, error flagged
    issue_wr(5'd3);
    wb0_valid = 1'b1; wb0_rd = 5'd3; wb1_valid = 1'b1; wb1_rd = 5'd3;
    step();
    idle();
    chk("same_busy", busy_a, 32'h0);
    chk("same_out", 32'(out_a), 32'd0);
    chk("same_err", 32'(err_a), 32'd1);

    // Async reset clears the sticky error without a clock edge
    async_reset();
    chk("areset_err", 32'(err_a), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Flush with four busy registers, concurrent issue is refused
    issue_wr(5'd1);
    issue_wr(5'd2);
    issue_wr(5'd3);
    issue_wr(5'd4);
    chk("fl_busy4", busy_a, 32'h0000_001E);
    chk("fl_out4", 32'(out_a), 32'd4);
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd20; iss_rd_we = 1'b1;
    #1 chk("fl_ready0", 32'(ready_a), 32'd0);
    step();
    idle();
    chk("fl_busy0", busy_a, 32'h0);
    chk("fl_out0", 32'(out_a), 32'd0);

    // Spurious completion sets err, which survives flush
    wb1_valid = 1'b1; wb1_rd = 5'd12;
    step();
    idle();
    chk("spur_err", 32'(err_a), 32'd1);
    chk("spur_busy", busy_a, 32'h0);
    flush = 1'b1;
    step();
    idle();
    chk("spur_err_flush", 32'(err_a), 32'd1);

    // Async reset mid-stream drops pending writes and the error immediately
    issue_wr(5'd6);
    chk("mid_busy6", busy_a, 32'h0000_0040);
    async_reset();
    chk("mid_busy", busy_a, 32'h0);
    chk("mid_out", 32'(out_a), 32'd0);
    chk("mid_err", 32'(err_a), 32'd0);
    chk("mid_ready", 32'(ready_a), 32'd1);
    step();
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no end of stimulus expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
